// File: rtl/kb_ascii_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : kb_ascii_fifo
//  Description : Set-2 scan-code decoder feeding a 7-bit ASCII character FIFO.
//                Break (F0) and extended (E0) sequences are filtered. Left and
//                right shift are tracked. Make codes are translated through a
//                registered stage, and the results are queued in a
//                first-word-fall-through FIFO that the CPU keyboard port reads.
//  Ports       : clk, rst_n              clock, async active-low reset
//                scan_byte, scan_valid   scan byte and its 1-cycle strobe
//                KB_read_en, KB_clear    CPU pop (level) and sync FIFO flush
//                KB_status, KB_data      non-empty flag, ASCII at FIFO head
//                buf_full, overflow      FIFO full, sticky drop flag
//  Revision    : 1.0  initial release
// ============================================================================
module kb_ascii_fifo #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] scan_byte,
   input  logic       scan_valid,
   input  logic       KB_read_en,
   input  logic       KB_clear,
   output logic       KB_status,
   output logic [6:0] KB_data,
   output logic       buf_full,
   output logic       overflow
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_BRK     = 2'd1,
      ST_EXT     = 2'd2,
      ST_EXT_BRK = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic        shift_q, shift_d;
   logic        stage_vld_q, stage_vld_d;
   logic [6:0]  stage_chr_q, stage_chr_d;

   logic        map_hit;
   logic        map_letter;
   logic [6:0]  map_chr;

   logic [6:0]  mem_q [DEPTH];
   logic [AW-1:0] rd_q, wr_q;
   logic [AW:0] count_q;
   logic        overflow_q;
   logic [6:0]  last_q;

   logic        w_empty, w_full, w_push, w_pop, w_wr, w_drop;

   // Make-code translation table; letters are stored lower case.
   always_comb begin
      map_hit    = 1'b1;
      map_letter = 1'b1;
      map_chr    = 7'h00;
      case (scan_byte)
         8'h1C: map_chr = 7'h61;  8'h32: map_chr = 7'h62;
         8'h21: map_chr = 7'h63;  8'h23: map_chr = 7'h64;
         8'h24: map_chr = 7'h65;  8'h2B: map_chr = 7'h66;
         8'h34: map_chr = 7'h67;  8'h33: map_chr = 7'h68;
         8'h43: map_chr = 7'h69;  8'h3B: map_chr = 7'h6A;
         8'h42: map_chr = 7'h6B;  8'h4B: map_chr = 7'h6C;
         8'h3A: map_chr = 7'h6D;  8'h31: map_chr = 7'h6E;
         8'h44: map_chr = 7'h6F;  8'h4D: map_chr = 7'h70;
         8'h15: map_chr = 7'h71;  8'h2D: map_chr = 7'h72;
         8'h1B: map_chr = 7'h73;  8'h2C: map_chr = 7'h74;
         8'h3C: map_chr = 7'h75;  8'h2A: map_chr = 7'h76;
         8'h1D: map_chr = 7'h77;  8'h22: map_chr = 7'h78;
         8'h35: map_chr = 7'h79;  8'h1A: map_chr = 7'h7A;
         default: begin
            map_letter = 1'b0;
            case (scan_byte)
               8'h45: map_chr = 7'h30;  8'h16: map_chr = 7'h31;
               8'h1E: map_chr = 7'h32;  8'h26: map_chr = 7'h33;
               8'h25: map_chr = 7'h34;  8'h2E: map_chr = 7'h35;
               8'h36: map_chr = 7'h36;  8'h3D: map_chr = 7'h37;
               8'h3E: map_chr = 7'h38;  8'h46: map_chr = 7'h39;
               8'h29: map_chr = 7'h20;  8'h5A: map_chr = 7'h0D;
               8'h66: map_chr = 7'h08;  8'h76: map_chr = 7'h1B;
               default: map_hit = 1'b0;
            endcase
         end
      endcase
   end

   // Decoder next-state logic; only a strobed byte can move the FSM.
   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      stage_vld_d = 1'b0;
      stage_chr_d = stage_chr_q;
      if (scan_valid) begin
         case (state_q)
            ST_IDLE: begin
               case (scan_byte)
                  8'hF0: state_d = ST_BRK;
                  8'hE0: state_d = ST_EXT;
                  8'h12, 8'h59: shift_d = 1'b1;
                  8'hE1, 8'hAA, 8'hFA, 8'hFE: ;
                  default: begin
                     if (map_hit) begin
                        stage_vld_d = 1'b1;
                        // Upper case is exactly 0x20 below lower case.
                        stage_chr_d = (map_letter && shift_q) ? (map_chr - 7'h20) : map_chr;
                     end
                  end
               endcase
            end
            ST_BRK: begin
               if (scan_byte == 8'h12 || scan_byte == 8'h59) begin
                  shift_d = 1'b0;
               end
               state_d = ST_IDLE;
            end
            ST_EXT:     state_d = (scan_byte == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
            ST_EXT_BRK: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end
      // A flush also discards whatever would land in the stage this cycle.
      if (KB_clear) begin
         stage_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         shift_q     <= 1'b0;
         stage_vld_q <= 1'b0;
         stage_chr_q <= 7'h00;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         stage_vld_q <= stage_vld_d;
         stage_chr_q <= stage_chr_d;
      end
   end

   // FIFO control. When full, a simultaneous pop frees the slot being written
   // (wr_q == rd_q), so push and pop both proceed and count stays at DEPTH.
   assign w_empty = (count_q == '0);
   assign w_full  = (count_q == FULL_CNT);
   assign w_push  = stage_vld_q;
   assign w_pop   = KB_read_en & ~w_empty;
   assign w_wr    = w_push & (~w_full | w_pop);
   assign w_drop  = w_push & w_full & ~w_pop;

   always_ff @(posedge clk) begin
      if (w_wr && !KB_clear) begin
         mem_q[wr_q] <= stage_chr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         last_q     <= 7'h00;
      end else if (KB_clear) begin
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         last_q     <= 7'h00;
      end else begin
         if (w_wr) begin
            wr_q <= wr_q + AW'(1);
         end
         if (w_pop) begin
            rd_q   <= rd_q + AW'(1);
            last_q <= mem_q[rd_q];
         end
         count_q <= count_q + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
         if (w_drop) begin
            overflow_q <= 1'b1;
         end
      end
   end

   // Fall-through head; when empty the last popped character stays visible.
   assign KB_status = ~w_empty;
   assign KB_data   = w_empty ? last_q : mem_q[rd_q];
   assign buf_full  = w_full;
   assign overflow  = overflow_q;

endmodule
`default_nettype wire
